// File: rtl/i2c_byte_sequencer.sv
// I2C master byte sequencer: frames one address byte and one data byte (write or read)
// with START/STOP, driven by the SCL timing block's strobes. Optional macro: I2C_ARB_LOST_EN.
`timescale 1ns/1ps

module i2c_byte_sequencer (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [6:0] i_addr,
  input  logic       i_rw,
  input  logic [7:0] i_wdata,
  input  logic       i_sda,
  input  logic       i_t_HD_STA_done,
  input  logic       i_t_HD_DAT_done,
  input  logic       i_t_VD_DAT_done,
  output logic [4:0] o_cmd_state,
  output logic       o_sda_oe,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_ack_err,
  output logic [7:0] o_rdata
`ifdef I2C_ARB_LOST_EN
  ,
  output logic       o_arb_lost
`endif
);

  typedef enum logic [4:0] {
    CMD_IDLE          = 5'd0,
    CMD_START         = 5'd1,
    CMD_DATA_TRANSFER = 5'd2,
    CMD_RESTART       = 5'd3,
    CMD_STOP          = 5'd4
  } cmd_e;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_DATA, S_DATA_ACK, S_STOP
  } state_e;

  state_e     r_state, w_state_nxt;
  cmd_e       r_cmd, w_cmd_nxt;
  logic       r_sda_oe, w_sda_oe_nxt;
  logic       r_busy, w_busy_nxt;
  logic       r_done, w_done_nxt;
  logic       r_ack_err, w_ack_err_nxt;
  logic [7:0] r_rdata, w_rdata_nxt;
  logic [2:0] r_bitcnt, w_bitcnt_nxt;
  logic [7:0] r_shreg, w_shreg_nxt;
  logic       r_rw, w_rw_nxt;
  logic [7:0] r_wdata, w_wdata_nxt;
  logic       w_last_bit;
`ifdef I2C_ARB_LOST_EN
  logic       r_arb_lost, w_arb_lost_nxt;
  logic       w_arb_hit;
`endif

  // Next-state and next-output decode; VD_DAT takes priority over a colliding HD_DAT.
  always_comb begin
    w_state_nxt   = r_state;
    w_sda_oe_nxt  = r_sda_oe;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    w_ack_err_nxt = r_ack_err;
    w_rdata_nxt   = r_rdata;
    w_bitcnt_nxt  = r_bitcnt;
    w_shreg_nxt   = r_shreg;
    w_rw_nxt      = r_rw;
    w_wdata_nxt   = r_wdata;
    w_cmd_nxt     = CMD_IDLE;
    w_last_bit    = (r_bitcnt == 3'd0);
`ifdef I2C_ARB_LOST_EN
    w_arb_lost_nxt = r_arb_lost;
    w_arb_hit      = i_t_VD_DAT_done && !r_sda_oe && !i_sda &&
                     ((r_state == S_ADDR) || ((r_state == S_DATA) && !r_rw));
`endif

    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_shreg_nxt   = {i_addr, i_rw};
          w_rw_nxt      = i_rw;
          w_wdata_nxt   = i_wdata;
          w_ack_err_nxt = 1'b0;
          w_busy_nxt    = 1'b1;
          w_sda_oe_nxt  = 1'b1;
          w_bitcnt_nxt  = 3'd7;
          w_state_nxt   = S_START;
`ifdef I2C_ARB_LOST_EN
          w_arb_lost_nxt = 1'b0;
`endif
        end
      end
      S_START: begin
        if (i_t_HD_STA_done) begin
          w_state_nxt  = S_ADDR;
          w_bitcnt_nxt = 3'd7;
        end
      end
      S_ADDR, S_DATA: begin
        if ((r_state == S_DATA) && r_rw) begin
          if (i_t_VD_DAT_done) begin
            w_rdata_nxt = {r_rdata[6:0], i_sda};
            if (w_last_bit) w_state_nxt = S_DATA_ACK;
            else            w_bitcnt_nxt = r_bitcnt - 3'd1;
          end else if (i_t_HD_DAT_done) begin
            w_sda_oe_nxt = 1'b0;
          end
        end else begin
          if (i_t_VD_DAT_done) begin
            if (w_last_bit) w_state_nxt = (r_state == S_ADDR) ? S_ADDR_ACK : S_DATA_ACK;
            else            w_bitcnt_nxt = r_bitcnt - 3'd1;
          end else if (i_t_HD_DAT_done) begin
            w_sda_oe_nxt = ~r_shreg[r_bitcnt];
          end
        end
      end
      S_ADDR_ACK: begin
        if (i_t_VD_DAT_done) begin
          if (i_sda) begin
            w_ack_err_nxt = 1'b1;
            w_state_nxt   = S_STOP;
          end else begin
            w_state_nxt  = S_DATA;
            w_bitcnt_nxt = 3'd7;
            w_shreg_nxt  = r_wdata;
          end
        end else if (i_t_HD_DAT_done) begin
          w_sda_oe_nxt = 1'b0;
        end
      end
      S_DATA_ACK: begin
        // On a read the master leaves SDA released here, i.e. NACKs the single byte.
        if (i_t_VD_DAT_done) begin
          if (!r_rw && i_sda) w_ack_err_nxt = 1'b1;
          w_state_nxt = S_STOP;
        end else if (i_t_HD_DAT_done) begin
          w_sda_oe_nxt = 1'b0;
        end
      end
      S_STOP: begin
        // SDA is only released once it has been pulled low in this SCL low phase.
        if (i_t_VD_DAT_done) begin
          if (r_sda_oe) begin
            w_sda_oe_nxt = 1'b0;
            w_done_nxt   = 1'b1;
            w_busy_nxt   = 1'b0;
            w_state_nxt  = S_IDLE;
          end
        end else if (i_t_HD_DAT_done) begin
          w_sda_oe_nxt = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

`ifdef I2C_ARB_LOST_EN
    // Lost arbitration: another master holds SDA low while we release it; abort silently.
    if (w_arb_hit) begin
      w_arb_lost_nxt = 1'b1;
      w_sda_oe_nxt   = 1'b0;
      w_busy_nxt     = 1'b0;
      w_state_nxt    = S_IDLE;
    end
`endif

    case (w_state_nxt)
      S_START:                                  w_cmd_nxt = CMD_START;
      S_ADDR, S_ADDR_ACK, S_DATA, S_DATA_ACK:   w_cmd_nxt = CMD_DATA_TRANSFER;
      S_STOP:                                   w_cmd_nxt = CMD_STOP;
      default:                                  w_cmd_nxt = CMD_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_cmd     <= CMD_IDLE;
      r_sda_oe  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_ack_err <= 1'b0;
      r_rdata   <= 8'd0;
      r_bitcnt  <= 3'd7;
      r_shreg   <= 8'd0;
      r_rw      <= 1'b0;
      r_wdata   <= 8'd0;
`ifdef I2C_ARB_LOST_EN
      r_arb_lost <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_cmd     <= w_cmd_nxt;
      r_sda_oe  <= w_sda_oe_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_ack_err <= w_ack_err_nxt;
      r_rdata   <= w_rdata_nxt;
      r_bitcnt  <= w_bitcnt_nxt;
      r_shreg   <= w_shreg_nxt;
      r_rw      <= w_rw_nxt;
      r_wdata   <= w_wdata_nxt;
`ifdef I2C_ARB_LOST_EN
      r_arb_lost <= w_arb_lost_nxt;
`endif
    end
  end

  assign o_cmd_state = r_cmd;
  assign o_sda_oe    = r_sda_oe;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_ack_err   = r_ack_err;
  assign o_rdata     = r_rdata;
`ifdef I2C_ARB_LOST_EN
  assign o_arb_lost  = r_arb_lost;
`endif

endmodule

// File: tb/tb_i2c_byte_sequencer.sv
// Bench for i2c_byte_sequencer: bit-slot model of each transaction checked at every sample strobe,
// plus literal byte/flag expectations per transaction.
`timescale 1ns/1ps

module tb_i2c_byte_sequencer;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_start = 1'b0;
  logic [6:0] i_addr = 7'd0;
  logic       i_rw = 1'b0;
  logic [7:0] i_wdata = 8'd0;
  logic       i_sda = 1'b1;
  logic       i_t_HD_STA_done = 1'b0;
  logic       i_t_HD_DAT_done = 1'b0;
  logic       i_t_VD_DAT_done = 1'b0;
  logic [4:0] o_cmd_state;
  logic       o_sda_oe, o_busy, o_done, o_ack_err;
  logic [7:0] o_rdata;
`ifdef I2C_ARB_LOST_EN
  logic       o_arb_lost;
`endif

  i2c_byte_sequencer dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_addr(i_addr), .i_rw(i_rw),
    .i_wdata(i_wdata), .i_sda(i_sda), .i_t_HD_STA_done(i_t_HD_STA_done),
    .i_t_HD_DAT_done(i_t_HD_DAT_done), .i_t_VD_DAT_done(i_t_VD_DAT_done),
    .o_cmd_state(o_cmd_state), .o_sda_oe(o_sda_oe), .o_busy(o_busy), .o_done(o_done),
    .o_ack_err(o_ack_err), .o_rdata(o_rdata)
`ifdef I2C_ARB_LOST_EN
    , .o_arb_lost(o_arb_lost)
`endif
  );

  always #50 i_clk = ~i_clk;

  typedef struct {
    logic       oe;
    logic [4:0] cmd;
    logic       sda;
  } slot_t;

  slot_t       slots[$];
  int          cur = 0;
  bit          cmp_en = 1'b0;
  logic [31:0] cap_line;
  logic        exp_ack_err;
  int          n_total = 0;
  int          n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Each bit slot = one SCL period; records what the master must drive at the sample point.
  task automatic build_model(input logic [6:0] addr, input logic rw, input logic [7:0] wdata,
                             input logic [7:0] sbyte, input logic anack, input logic dnack);
    logic [7:0] bits;
    logic       o;
    slots.delete();
    bits = {addr, rw};
    for (int i = 0; i < 8; i++) begin
      o = ~bits[7-i];
      slots.push_back('{oe: o, cmd: 5'd2, sda: ~o});
    end
    slots.push_back('{oe: 1'b0, cmd: 5'd2, sda: anack});
    if (!anack) begin
      for (int i = 0; i < 8; i++) begin
        if (!rw) begin
          o = ~wdata[7-i];
          slots.push_back('{oe: o, cmd: 5'd2, sda: ~o});
        end else begin
          slots.push_back('{oe: 1'b0, cmd: 5'd2, sda: sbyte[7-i]});
        end
      end
      slots.push_back('{oe: 1'b0, cmd: 5'd2, sda: rw ? 1'b1 : dnack});
    end
    slots.push_back('{oe: 1'b1, cmd: 5'd4, sda: 1'b0});
    exp_ack_err = anack | (~rw & dnack);
  endtask

  function automatic logic [7:0] cap_byte(input int base);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[7-i] = cap_line[base+i];
    return b;
  endfunction

  // Compare process: at every sample strobe the master's SDA drive and command must match the model.
  always @(negedge i_clk) begin
    if (cmp_en && i_t_VD_DAT_done) begin
      chk("sda_oe_at_sample", 32'(o_sda_oe), 32'(slots[cur].oe));
      chk("cmd_at_sample", 32'(o_cmd_state), 32'(slots[cur].cmd));
      chk("busy_at_sample", 32'(o_busy), 32'd1);
      chk("done_at_sample", 32'(o_done), 32'd0);
      if (cur < 32) cap_line[cur] = ~o_sda_oe;
    end
  end

  task automatic run_txn(input logic [6:0] addr, input logic rw, input logic [7:0] wdata,
                         input logic [7:0] sbyte, input logic anack, input logic dnack,
                         input int glitch_slot, input int rst_slot, input int arb_slot);
    build_model(addr, rw, wdata, sbyte, anack, dnack);
    if (arb_slot >= 0) slots[arb_slot].sda = 1'b0;
    cap_line = '0;
    chk("cmd_idle_before", 32'(o_cmd_state), 32'd0);
    step();
    i_start = 1'b1; i_addr = addr; i_rw = rw; i_wdata = wdata;
    step();
    i_start = 1'b0;
    chk("cmd_start", 32'(o_cmd_state), 32'd1);
    chk("oe_start", 32'(o_sda_oe), 32'd1);
    chk("busy_start", 32'(o_busy), 32'd1);
    chk("ack_err_cleared", 32'(o_ack_err), 32'd0);
    step(); step();
    i_t_HD_STA_done = 1'b1;
    step();
    i_t_HD_STA_done = 1'b0;
    chk("cmd_addr", 32'(o_cmd_state), 32'd2);
    cmp_en = 1'b1;
    for (int s = 0; s < slots.size(); s++) begin
      if (s == glitch_slot) begin
        i_start = 1'b1; i_addr = 7'h7F; i_rw = ~rw; i_wdata = ~wdata;
        step();
        i_start = 1'b0;
        chk("busy_after_glitch", 32'(o_busy), 32'd1);
      end
      cur = s;
      i_t_HD_DAT_done = 1'b1;
      step();
      i_t_HD_DAT_done = 1'b0;
      i_sda = slots[s].sda;
      if (s == rst_slot) begin
        chk("oe_before_rst", 32'(o_sda_oe), 32'd1);
        #5 i_rst = 1'b1;
        #5;
        chk("oe_async_rst", 32'(o_sda_oe), 32'd0);
        chk("cmd_async_rst", 32'(o_cmd_state), 32'd0);
        chk("busy_async_rst", 32'(o_busy), 32'd0);
        cmp_en = 1'b0;
        i_sda = 1'b1;
        step();
        i_rst = 1'b0;
        step();
        return;
      end
      step();
      i_t_VD_DAT_done = 1'b1;
      step();
      i_t_VD_DAT_done = 1'b0;
      i_sda = 1'b1;
      if (s == arb_slot) begin
        cmp_en = 1'b0;
`ifdef I2C_ARB_LOST_EN
        chk("arb_lost", 32'(o_arb_lost), 32'd1);
`endif
        chk("busy_arb", 32'(o_busy), 32'd0);
        chk("cmd_arb", 32'(o_cmd_state), 32'd0);
        chk("oe_arb", 32'(o_sda_oe), 32'd0);
        chk("done_arb", 32'(o_done), 32'd0);
        step();
        chk("done_arb_later", 32'(o_done), 32'd0);
        return;
      end
    end
    cmp_en = 1'b0;
    chk("done_pulse", 32'(o_done), 32'd1);
    chk("busy_end", 32'(o_busy), 32'd0);
    chk("cmd_end", 32'(o_cmd_state), 32'd0);
    chk("oe_end", 32'(o_sda_oe), 32'd0);
    chk("ack_err_end", 32'(o_ack_err), 32'(exp_ack_err));
    step();
    chk("done_single", 32'(o_done), 32'd0);
    chk("ack_err_held", 32'(o_ack_err), 32'(exp_ack_err));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    step(); step();
    i_rst = 1'b0;
    step();
    chk("rst_cmd", 32'(o_cmd_state), 32'd0);
    chk("rst_oe", 32'(o_sda_oe), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_ack_err", 32'(o_ack_err), 32'd0);
    chk("rst_rdata", 32'(o_rdata), 32'd0);

    // Strobes in IDLE are ignored
    i_sda = 1'b0;
    i_t_HD_STA_done = 1'b1; i_t_HD_DAT_done = 1'b1;
    step();
    i_t_HD_STA_done = 1'b0; i_t_HD_DAT_done = 1'b0; i_t_VD_DAT_done = 1'b1;
    step();
    i_t_VD_DAT_done = 1'b0; i_sda = 1'b1;
    step();
    chk("idle_strobe_cmd", 32'(o_cmd_state), 32'd0);
    chk("idle_strobe_oe", 32'(o_sda_oe), 32'd0);
    chk("idle_strobe_busy", 32'(o_busy), 32'd0);

    // Write 0x50 / 0xA5, both ACKed
    run_txn(7'h50, 1'b0, 8'hA5, 8'h00, 1'b0, 1'b0, -1, -1, -1);
    chk("wr_addr_bits", 32'(cap_byte(0)), 32'hA0);
    chk("wr_data_bits", 32'(cap_byte(9)), 32'hA5);
    chk("wr_ack_err", 32'(o_ack_err), 32'd0);

    // Read 0x3C, slave returns 0x96
    run_txn(7'h3C, 1'b1, 8'h00, 8'h96, 1'b0, 1'b0, -1, -1, -1);
    chk("rd_addr_bits", 32'(cap_byte(0)), 32'h79);
    chk("rd_rdata", 32'(o_rdata), 32'h96);
    chk("rd_ack_err", 32'(o_ack_err), 32'd0);

    // Write 0x11, address NACKed: data phase skipped
    run_txn(7'h11, 1'b0, 8'hFF, 8'h00, 1'b1, 1'b0, -1, -1, -1);
    chk("nack_ack_err", 32'(o_ack_err), 32'd1);
    chk("nack_slot_count", 32'(slots.size()), 32'd10);

    // Write 0x2A / 0x3C with data NACK and an i_start pulse mid-address
    run_txn(7'h2A, 1'b0, 8'h3C, 8'h00, 1'b0, 1'b1, 3, -1, -1);
    chk("glitch_addr_bits", 32'(cap_byte(0)), 32'h54);
    chk("glitch_data_bits", 32'(cap_byte(9)), 32'h3C);
    chk("dnack_ack_err", 32'(o_ack_err), 32'd1);

    // Reset during data bit 4, then a clean transaction
    run_txn(7'h50, 1'b0, 8'hA5, 8'h00, 1'b0, 1'b0, -1, 12, -1);
    chk("post_rst_ack_err", 32'(o_ack_err), 32'd0);
    chk("post_rst_busy", 32'(o_busy), 32'd0);
    run_txn(7'h23, 1'b0, 8'h5A, 8'h00, 1'b0, 1'b0, -1, -1, -1);
    chk("clean_addr_bits", 32'(cap_byte(0)), 32'h46);
    chk("clean_data_bits", 32'(cap_byte(9)), 32'h5A);

`ifdef I2C_ARB_LOST_EN
    // Another master holds SDA low on the address MSB
    run_txn(7'h50, 1'b0, 8'hA5, 8'h00, 1'b0, 1'b0, -1, -1, 0);
    chk("arb_lost_held", 32'(o_arb_lost), 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
